// File: rtl/multi_buffer_pkg.sv
// Shared types and constants for the multi-bank generation buffer.
package multi_buffer_pkg;

  typedef logic [15:0] data_t;

  localparam int MB_MAX_BANKS = 4;

  typedef enum logic {
    MB_CLEAR,
    MB_RUN
  } mb_state_t;

  function automatic logic [15:0] mb_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mb_bank_ram.sv
// One board bank: true dual-port RAM, port A read/write, port B read-only,
// both with a single registered read stage.
module mb_bank_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [WIDTH-1:0]  a_wdata_i,
  output logic [WIDTH-1:0]  a_rdata_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [WIDTH-1:0]  b_rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a_rdata_q;
  logic [WIDTH-1:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem[a_addr_i] <= a_wdata_i;
    end
    a_rdata_q <= mem[a_addr_i];
    b_rdata_q <= mem[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/multi_buffer.sv
// N-bank game-of-life generation buffer with frame-synchronised role rotation.
// Define MULTI_BUFFER_STATS_EN to add skipped-generation and stall counters.
module multi_buffer
  import multi_buffer_pkg::*;
#(
  parameter int NUM_BANKS = 3,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4096,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BANK_W = $clog2(NUM_BANKS)
) (
  input  logic              clk_130mhz,
  input  logic              rst_n_in,
  input  logic              frame_done_in,
  input  logic              swap_req_in,
  output logic              swap_ack_out,
  input  logic [ADDR_W-1:0] render_addr_in,
  output logic [WIDTH-1:0]  render_data_out,
  input  logic [ADDR_W-1:0] logic_addr_r_in,
  output logic [WIDTH-1:0]  logic_data_r_out,
  input  logic [ADDR_W-1:0] logic_addr_w_in,
  input  logic [WIDTH-1:0]  logic_data_w_in,
  input  logic              logic_wr_en_in,
`ifdef MULTI_BUFFER_STATS_EN
  output logic [15:0]       skipped_gen_out,
  output logic [15:0]       stall_cycles_out,
`endif
  output logic              ready_out,
  output logic [BANK_W-1:0] disp_bank_out
);

  mb_state_t         state_q;
  logic [ADDR_W-1:0] clear_addr_q;
  logic [BANK_W-1:0] disp_q, src_q, dst_q;
  logic [BANK_W-1:0] disp_d, src_d, dst_d;
  logic              fresh_q, fresh_d;
  logic              ready_q, ack_q, rd_valid_q;
  logic [BANK_W-1:0] logic_sel_q, render_sel_q;

  logic [BANK_W-1:0] alt_disp, free_bank;
  logic              free_found, accept;

  // A free bank must avoid both the bank that will be displayed and the
  // bank being promoted to src; the lowest such index becomes the new dst.
  always_comb begin
    alt_disp   = frame_done_in ? dst_q : disp_q;
    free_found = 1'b0;
    free_bank  = '0;
    for (int f = NUM_BANKS - 1; f >= 0; f--) begin
      if (BANK_W'(f) != alt_disp && BANK_W'(f) != dst_q) begin
        free_found = 1'b1;
        free_bank  = BANK_W'(f);
      end
    end
    // The cycle showing the ack is blocked so a still-held request is not taken twice.
    accept = (state_q == MB_RUN) && swap_req_in && !ack_q && free_found;

    disp_d  = disp_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fresh_d = fresh_q;
    if (accept) begin
      src_d = dst_q;
      dst_d = free_bank;
      if (frame_done_in) begin
        disp_d  = dst_q;
        fresh_d = 1'b0;
      end else begin
        fresh_d = 1'b1;
      end
    end else if (frame_done_in && fresh_q) begin
      disp_d  = src_q;
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= MB_CLEAR;
      clear_addr_q <= '0;
      disp_q       <= '0;
      src_q        <= '0;
      dst_q        <= BANK_W'(1);
      fresh_q      <= 1'b0;
      ready_q      <= 1'b0;
      ack_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      logic_sel_q  <= '0;
      render_sel_q <= '0;
    end else begin
      // Read-mux selects follow the roles at address issue time.
      logic_sel_q  <= src_q;
      render_sel_q <= disp_q;
      rd_valid_q   <= (state_q == MB_RUN);
      case (state_q)
        MB_CLEAR: begin
          ack_q <= 1'b0;
          if (clear_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= MB_RUN;
            ready_q <= 1'b1;
          end else begin
            clear_addr_q <= clear_addr_q + 1'b1;
          end
        end
        MB_RUN: begin
          disp_q  <= disp_d;
          src_q   <= src_d;
          dst_q   <= dst_d;
          fresh_q <= fresh_d;
          ack_q   <= accept;
        end
      endcase
    end
  end

  logic [WIDTH-1:0] a_rdata [NUM_BANKS];
  logic [WIDTH-1:0] b_rdata [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [WIDTH-1:0]  wdata_a;

    always_comb begin
      we      = 1'b0;
      addr_a  = logic_addr_r_in;
      wdata_a = logic_data_w_in;
      if (state_q == MB_CLEAR) begin
        we      = 1'b1;
        addr_a  = clear_addr_q;
        wdata_a = CLEAR_VALUE;
      end else if (dst_q == BANK_W'(gi)) begin
        we     = logic_wr_en_in;
        addr_a = logic_addr_w_in;
      end
    end

    mb_bank_ram #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_ram (
      .clk_i    (clk_130mhz),
      .a_we_i   (we),
      .a_addr_i (addr_a),
      .a_wdata_i(wdata_a),
      .a_rdata_o(a_rdata[gi]),
      .b_addr_i (render_addr_in),
      .b_rdata_o(b_rdata[gi])
    );
  end

  assign logic_data_r_out = rd_valid_q ? a_rdata[logic_sel_q] : '0;
  assign render_data_out  = rd_valid_q ? b_rdata[render_sel_q] : '0;
  assign swap_ack_out     = ack_q;
  assign ready_out        = ready_q;
  assign disp_bank_out    = disp_q;

`ifdef MULTI_BUFFER_STATS_EN
  logic [15:0] skipped_q, stall_q;

  always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      skipped_q <= '0;
      stall_q   <= '0;
    end else if (state_q == MB_CLEAR) begin
      skipped_q <= '0;
      stall_q   <= '0;
    end else begin
      if (accept && fresh_q && !frame_done_in) begin
        skipped_q <= mb_sat_inc(skipped_q);
      end
      if (swap_req_in && !accept && !ack_q) begin
        stall_q <= mb_sat_inc(stall_q);
      end
    end
  end

  assign skipped_gen_out  = skipped_q;
  assign stall_cycles_out = stall_q;
`endif

endmodule

// File: tb/tb_multi_buffer.sv
// Directed bench: a 3-bank and a 2-bank buffer (DEPTH=16) side by side.
// Stats checks are compiled only when MULTI_BUFFER_STATS_EN is defined.
module tb_multi_buffer;
  localparam int DEPTH = 16;
  localparam logic [15:0] CLR_A = 16'h5A5A;
  localparam logic [15:0] CLR_B = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        a_rst_n, a_frame, a_req, a_wen, a_ack, a_ready;
  logic [3:0]  a_raddr, a_waddr, a_vaddr;
  logic [15:0] a_wdata, a_rdata, a_vdata;
  logic [1:0]  a_disp;

  logic        b_rst_n, b_frame, b_req, b_wen, b_ack, b_ready;
  logic [3:0]  b_raddr, b_waddr, b_vaddr;
  logic [15:0] b_wdata, b_rdata, b_vdata;
  logic [0:0]  b_disp;
`ifdef MULTI_BUFFER_STATS_EN
  logic [15:0] a_skip, a_stall, b_skip, b_stall;
`endif

  multi_buffer #(.NUM_BANKS(3), .WIDTH(16), .DEPTH(DEPTH), .CLEAR_VALUE(CLR_A)) u_a (
    .clk_130mhz(clk), .rst_n_in(a_rst_n), .frame_done_in(a_frame),
    .swap_req_in(a_req), .swap_ack_out(a_ack),
    .render_addr_in(a_vaddr), .render_data_out(a_vdata),
    .logic_addr_r_in(a_raddr), .logic_data_r_out(a_rdata),
    .logic_addr_w_in(a_waddr), .logic_data_w_in(a_wdata), .logic_wr_en_in(a_wen),
`ifdef MULTI_BUFFER_STATS_EN
    .skipped_gen_out(a_skip), .stall_cycles_out(a_stall),
`endif
    .ready_out(a_ready), .disp_bank_out(a_disp)
  );

  multi_buffer #(.NUM_BANKS(2), .WIDTH(16), .DEPTH(DEPTH), .CLEAR_VALUE(CLR_B)) u_b (
    .clk_130mhz(clk), .rst_n_in(b_rst_n), .frame_done_in(b_frame),
    .swap_req_in(b_req), .swap_ack_out(b_ack),
    .render_addr_in(b_vaddr), .render_data_out(b_vdata),
    .logic_addr_r_in(b_raddr), .logic_data_r_out(b_rdata),
    .logic_addr_w_in(b_waddr), .logic_data_w_in(b_wdata), .logic_wr_en_in(b_wen),
`ifdef MULTI_BUFFER_STATS_EN
    .skipped_gen_out(b_skip), .stall_cycles_out(b_stall),
`endif
    .ready_out(b_ready), .disp_bank_out(b_disp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release at a falling edge; ready must be seen right after the DEPTH-th
  // rising edge (the release cycle counts as cycle 1, so ready is high in cycle DEPTH+1).
  task automatic wait_ready_a(input string tag);
    int n;
    @(negedge clk);
    a_rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (a_ready === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++;
      $display("FAIL %s ready_edges: got %0d required %0d", tag, n, DEPTH);
    end
    $display("txn %s: ready after %0d edges", tag, n);
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 5;
    if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b required 0", a_ready); end
    if (a_ack !== 1'b0)   begin n_bad++; $display("FAIL rst_ack: got %b required 0", a_ack); end
    if (a_disp !== 2'd0)  begin n_bad++; $display("FAIL rst_disp: got %0d required 0", a_disp); end
    if (a_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_logic_data: got %h required 0000", a_rdata); end
    if (a_vdata !== 16'h0) begin n_bad++; $display("FAIL rst_render_data: got %h required 0000", a_vdata); end
    @(negedge clk);
    b_rst_n = 1'b1;
    wait_ready_a("reset_a");
    n_cmp++;
    if (b_ready !== 1'b1) begin n_bad++; $display("FAIL ready_b: got %b required 1", b_ready); end
  endtask

  task automatic test_clear_contents();
    for (int ad = 0; ad < DEPTH; ad++) begin
      a_raddr = 4'(ad);
      a_vaddr = 4'(ad);
      tick();
      n_cmp += 2;
      if (a_rdata !== CLR_A) begin n_bad++; $display("FAIL clear_logic[%0d]: got %h required %h", ad, a_rdata, CLR_A); end
      if (a_vdata !== CLR_A) begin n_bad++; $display("FAIL clear_render[%0d]: got %h required %h", ad, a_vdata, CLR_A); end
    end
    $display("txn clear_contents: %0d addresses read on both ports", DEPTH);
  endtask

  task automatic test_swap_nb3();
    // Write dst(1)[5]=00AA and request a swap on the same cycle.
    a_waddr = 4'd5; a_wdata = 16'h00AA; a_wen = 1'b1; a_req = 1'b1;
    tick();
    n_cmp += 2;
    if (a_ack !== 1'b1)  begin n_bad++; $display("FAIL swap3_ack: got %b required 1", a_ack); end
    if (a_disp !== 2'd0) begin n_bad++; $display("FAIL swap3_disp: got %0d required 0", a_disp); end
    // Now src=1, dst=2: write dst[5]=00BB, read src[5] and disp[5].
    a_req = 1'b0; a_wdata = 16'h00BB; a_raddr = 4'd5; a_vaddr = 4'd5;
    tick();
    n_cmp += 3;
    if (a_ack !== 1'b0)      begin n_bad++; $display("FAIL swap3_ack_pulse: got %b required 0", a_ack); end
    if (a_rdata !== 16'h00AA) begin n_bad++; $display("FAIL swap3_src_read: got %h required 00aa", a_rdata); end
    if (a_vdata !== CLR_A)   begin n_bad++; $display("FAIL swap3_disp_read: got %h required %h", a_vdata, CLR_A); end
    // Frame boundary: fresh src becomes disp; the read issued this cycle still sees bank 0.
    a_wen = 1'b0; a_frame = 1'b1;
    tick();
    n_cmp += 2;
    if (a_disp !== 2'd1)   begin n_bad++; $display("FAIL frame_disp: got %0d required 1", a_disp); end
    if (a_vdata !== CLR_A) begin n_bad++; $display("FAIL frame_inflight_read: got %h required %h", a_vdata, CLR_A); end
    a_frame = 1'b0;
    tick();
    n_cmp++;
    if (a_vdata !== 16'h00AA) begin n_bad++; $display("FAIL frame_new_disp_read: got %h required 00aa", a_vdata); end
    $display("txn swap_nb3: disp=%0d render=%h", a_disp, a_vdata);
  endtask

  task automatic test_swap_with_frame_nb3();
    // Roles disp=1 src=1 dst=2; swap with frame_done -> src=disp=2, dst=0.
    a_req = 1'b1; a_frame = 1'b1;
    tick();
    n_cmp += 2;
    if (a_ack !== 1'b1)  begin n_bad++; $display("FAIL swapf_ack: got %b required 1", a_ack); end
    if (a_disp !== 2'd2) begin n_bad++; $display("FAIL swapf_disp: got %0d required 2", a_disp); end
    a_req = 1'b0; a_frame = 1'b0;
    tick();
    n_cmp += 2;
    if (a_rdata !== 16'h00BB) begin n_bad++; $display("FAIL swapf_src_read: got %h required 00bb", a_rdata); end
    if (a_vdata !== 16'h00BB) begin n_bad++; $display("FAIL swapf_disp_read: got %h required 00bb", a_vdata); end
    $display("txn swap_frame_nb3: disp=%0d src_data=%h", a_disp, a_rdata);
  endtask

  task automatic test_strict_nb2();
    b_req = 1'b1; b_waddr = 4'd3; b_wdata = 16'h1234; b_wen = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      b_wen = 1'b0;
      n_cmp++;
      if (b_ack !== 1'b0) begin n_bad++; $display("FAIL nb2_early_ack[%0d]: got %b required 0", c, b_ack); end
    end
    b_frame = 1'b1;
    tick();
    n_cmp += 2;
    if (b_ack !== 1'b1)  begin n_bad++; $display("FAIL nb2_ack: got %b required 1", b_ack); end
    if (b_disp !== 1'b1) begin n_bad++; $display("FAIL nb2_disp: got %0d required 1", b_disp); end
    // src=disp=1 holds 1234; dst=0 receives 4321.
    b_req = 1'b0; b_frame = 1'b0; b_raddr = 4'd3; b_vaddr = 4'd3;
    b_wen = 1'b1; b_wdata = 16'h4321;
    tick();
    b_wen = 1'b0;
    tick();
    n_cmp += 3;
    if (b_ack !== 1'b0)       begin n_bad++; $display("FAIL nb2_ack_pulse: got %b required 0", b_ack); end
    if (b_rdata !== 16'h1234) begin n_bad++; $display("FAIL nb2_src_read: got %h required 1234", b_rdata); end
    if (b_vdata !== 16'h1234) begin n_bad++; $display("FAIL nb2_disp_read: got %h required 1234", b_vdata); end
    $display("txn strict_nb2: disp=%0d data=%h", b_disp, b_rdata);
  endtask

`ifdef MULTI_BUFFER_STATS_EN
  task automatic test_stats();
    // From disp=2 dst=0: three swaps with no frame; the 2nd and 3rd overwrite an undisplayed src.
    for (int s = 0; s < 3; s++) begin
      a_req = 1'b1;
      tick();
      a_req = 1'b0;
      n_cmp += 2;
      if (a_ack !== 1'b1)  begin n_bad++; $display("FAIL stats_ack[%0d]: got %b required 1", s, a_ack); end
      if (a_disp !== 2'd2) begin n_bad++; $display("FAIL stats_disp[%0d]: got %0d required 2", s, a_disp); end
      tick();
    end
    n_cmp += 3;
    if (a_skip !== 16'd2)  begin n_bad++; $display("FAIL stats_skipped: got %0d required 2", a_skip); end
    if (a_stall !== 16'd0) begin n_bad++; $display("FAIL stats_stall_a: got %0d required 0", a_stall); end
    if (b_stall !== 16'd9) begin n_bad++; $display("FAIL stats_stall_b: got %0d required 9", b_stall); end
    $display("txn stats: skipped=%0d stall_b=%0d", a_skip, b_stall);
  endtask
`endif

  task automatic test_reset_mid();
    // Reset in the middle of a pending swap: outputs drop without a clock edge.
    a_req = 1'b1;
    #2;
    a_rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (a_ready !== 1'b0)  begin n_bad++; $display("FAIL midswap_ready: got %b required 0", a_ready); end
    if (a_ack !== 1'b0)    begin n_bad++; $display("FAIL midswap_ack: got %b required 0", a_ack); end
    if (a_disp !== 2'd0)   begin n_bad++; $display("FAIL midswap_disp: got %0d required 0", a_disp); end
    if (a_rdata !== 16'h0) begin n_bad++; $display("FAIL midswap_logic_data: got %h required 0000", a_rdata); end
    if (a_vdata !== 16'h0) begin n_bad++; $display("FAIL midswap_render_data: got %h required 0000", a_vdata); end
    a_req = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (5) tick();
    #2;
    a_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_ready !== 1'b0) begin n_bad++; $display("FAIL midclear_ready: got %b required 0", a_ready); end
    wait_ready_a("midclear_restart");
    // Bank 1 held 00AA at address 5 before the reset; the clear must have rewritten it.
    a_req = 1'b1; a_raddr = 4'd5;
    tick();
    a_req = 1'b0;
    tick();
    n_cmp += 2;
    if (a_disp !== 2'd0)   begin n_bad++; $display("FAIL reclear_disp: got %0d required 0", a_disp); end
    if (a_rdata !== CLR_A) begin n_bad++; $display("FAIL reclear_bank1: got %h required %h", a_rdata, CLR_A); end
    $display("txn reset_mid: bank1[5]=%h", a_rdata);
  endtask

  initial begin
    a_rst_n = 1'b0; a_frame = 1'b0; a_req = 1'b0; a_wen = 1'b0;
    a_raddr = '0; a_waddr = '0; a_vaddr = '0; a_wdata = '0;
    b_rst_n = 1'b0; b_frame = 1'b0; b_req = 1'b0; b_wen = 1'b0;
    b_raddr = '0; b_waddr = '0; b_vaddr = '0; b_wdata = '0;
    test_reset();
    test_clear_contents();
    test_swap_nb3();
    test_swap_with_frame_nb3();
    test_strict_nb2();
`ifdef MULTI_BUFFER_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
